inert_cal_seq: RTL

- Calibration sequencer for the inertial integrator.
- On request, waits for the airframe to be still and the sensor stream to settle, then pulses strt_cal.
- Supervises cal_done with a sample-count timeout and a vld-stall watchdog, retries on failure, and reports ready/error status to the command processor.
- Sits between the command processor and the inertial integrator/inertial interface pair.

---
 rtl/inert_cal_pkg.sv | 37 +++
 rtl/inert_cal_seq_vld_watchdog.sv | 35 +++
 rtl/inert_cal_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/inert_cal_pkg.sv
// Shared types and timing constants for the inertial calibration sequencer.
// Settle/timeout lengths come in a short simulation flavour and a full flavour.
package inert_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT_DONE,
        RUN,
        FAIL
    } cal_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_TIMEOUT,
        ERR_STALL,
        ERR_MOTION
    } cal_err_e;

    localparam int SETTLE_W = 7;
    localparam int TMO_W    = 13;

    localparam logic [SETTLE_W-1:0] SETTLE_FAST = 7'd4;
    localparam logic [SETTLE_W-1:0] SETTLE_FULL = 7'd64;
    localparam logic [TMO_W-1:0]    TMO_FAST    = 13'd16;
    localparam logic [TMO_W-1:0]    TMO_FULL    = 13'd4096;

    function automatic logic [SETTLE_W-1:0] settle_len(input int fast_sim);
        return (fast_sim != 0) ? SETTLE_FAST : SETTLE_FULL;
    endfunction

    function automatic logic [TMO_W-1:0] tmo_len(input int fast_sim);
        return (fast_sim != 0) ? TMO_FAST : TMO_FULL;
    endfunction

endpackage

// File: rtl/inert_cal_seq_vld_watchdog.sv
// Sample-stream stall detector: counts enabled clocks since the last vld and
// flags a stall on the VLD_WD-th consecutive clock without one.
module vld_watchdog #(
    parameter logic [15:0] VLD_WD = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic vld,
    output logic stall
);

    logic [15:0] cnt_q, cnt_d;

    // A vld in the same cycle as the limit rescues the stream.
    assign stall = en && !vld && (cnt_q == VLD_WD - 16'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (vld || !en) begin
            cnt_d = '0;
        end else if (!stall) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inert_cal_seq.sv
// Calibration sequencer: settle, pulse strt_cal, supervise cal_done, retry, report.
// Define CAL_STAT_CNT_EN to add cal_count, a saturating count of successful calibrations.
module inert_cal_seq
    import inert_cal_pkg::*;
#(
    parameter int          FAST_SIM  = 1,
    parameter int          MAX_RETRY = 2,
    parameter logic [15:0] VLD_WD    = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cal_req,
    input  logic       motors_off,
    input  logic       vld,
    input  logic       cal_done,
    output logic       strt_cal,
    output logic       cal_busy,
    output logic       cal_ok,
    output logic       cal_err,
    output logic [1:0] err_code,
    output logic [1:0] retry_cnt
`ifdef CAL_STAT_CNT_EN
    ,
    output logic [7:0] cal_count
`endif
);

    localparam logic [SETTLE_W-1:0] SETTLE_N = settle_len(FAST_SIM);
    localparam logic [TMO_W-1:0]    TMO_N    = tmo_len(FAST_SIM);

    cal_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d, settle_inc;
    logic [TMO_W-1:0]    tmo_q, tmo_d, tmo_inc;
    logic [1:0]          retry_q, retry_d;
    cal_err_e            err_q, err_d;
    cal_err_e            fail_code;
    logic                fail_evt;
    logic                wd_en;
    logic                stall;

    assign settle_inc = settle_q + 1'b1;
    assign tmo_inc    = tmo_q + 1'b1;
    assign wd_en      = (state_q != IDLE) && (state_q != FAIL);

    vld_watchdog #(
        .VLD_WD(VLD_WD)
    ) u_wd (
        .clk  (clk),
        .rst  (rst),
        .en   (wd_en),
        .vld  (vld),
        .stall(stall)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        err_d     = err_q;
        fail_evt  = 1'b0;
        fail_code = ERR_NONE;
        // A stalled sample stream is fatal in any supervised state and is never retried.
        if (stall) begin
            state_d = FAIL;
            err_d   = ERR_STALL;
        end else begin
            case (state_q)
                IDLE, RUN, FAIL: begin
                    if (cal_req) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                        retry_d  = '0;
                        err_d    = ERR_NONE;
                    end
                end
                SETTLE: begin
                    if (!motors_off) begin
                        settle_d = '0;
                    end else if (vld) begin
                        if (settle_inc == SETTLE_N) begin
                            state_d  = START;
                            settle_d = '0;
                        end else begin
                            settle_d = settle_inc;
                        end
                    end
                end
                START: begin
                    tmo_d   = '0;
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    // cal_done wins over a timeout landing in the same cycle.
                    if (cal_done) begin
                        state_d = RUN;
                    end else if (!motors_off) begin
                        fail_evt  = 1'b1;
                        fail_code = ERR_MOTION;
                    end else if (vld) begin
                        if (tmo_inc == TMO_N) begin
                            fail_evt  = 1'b1;
                            fail_code = ERR_TIMEOUT;
                        end else begin
                            tmo_d = tmo_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            // A retry goes back through a fresh settle so the integrator gets a new strt_cal.
            if (fail_evt) begin
                if (int'(retry_q) < MAX_RETRY) begin
                    retry_d  = retry_q + 2'd1;
                    settle_d = '0;
                    state_d  = SETTLE;
                end else begin
                    state_d = FAIL;
                    err_d   = fail_code;
                end
            end
        end
    end

`ifdef CAL_STAT_CNT_EN
    logic [7:0] cal_count_q, cal_count_d;

    always_comb begin
        cal_count_d = cal_count_q;
        if ((state_q == WAIT_DONE) && (state_d == RUN) && (cal_count_q != 8'hFF)) begin
            cal_count_d = cal_count_q + 8'd1;
        end
    end

    assign cal_count = cal_count_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            err_q    <= ERR_NONE;
`ifdef CAL_STAT_CNT_EN
            cal_count_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
`ifdef CAL_STAT_CNT_EN
            cal_count_q <= cal_count_d;
`endif
        end
    end

    assign strt_cal  = (state_q == START);
    assign cal_busy  = (state_q == SETTLE) || (state_q == START) || (state_q == WAIT_DONE);
    assign cal_ok    = (state_q == RUN);
    assign cal_err   = (state_q == FAIL);
    assign err_code  = err_q;
    assign retry_cnt = retry_q;

endmodule
